// File: rtl/globefish_pkg.sv
// Shared definitions for the globefish_soc memory-side blocks: arbiter
// state encoding and Wishbone data/select widths.
package globefish_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from
// last+1 upward with wrap. LW must equal $clog2(NUM_REQ).
module rr_pick #(
  parameter int NUM_REQ = 8,
  parameter int LW      = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [LW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = LW'((int'(last) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qspi_mem_arb.sv
// Round-robin arbiter sharing the QSPI XIP memory controller among cores.
// Optional watchdog: define QSPI_MEM_ARB_TIMEOUT_EN to enable req_err_o.
module qspi_mem_arb
  import globefish_pkg::*;
#(
  parameter int NUM_REQ     = 8,
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        en_mask_i,
  input  logic [NUM_REQ-1:0]        req_cyc_i,
  input  logic [NUM_REQ-1:0]        req_stb_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*WB_SELW-1:0] req_sel_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_adr_i,
  input  logic [NUM_REQ*WB_DW-1:0]  req_dat_i,
  output logic [WB_DW-1:0]          req_dat_o,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic                      dn_cyc_o,
  output logic                      dn_stb_o,
  output logic                      dn_we_o,
  output logic [WB_SELW-1:0]        dn_sel_o,
  output logic [ADDR_W-1:0]         dn_adr_o,
  output logic [WB_DW-1:0]          dn_dat_o,
  input  logic [WB_DW-1:0]          dn_dat_i,
  input  logic                      dn_ack_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("qspi_mem_arb: TIMEOUT_CYC must be at least 2");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LW-1:0]      last_q, last_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_vld;
  logic [LW-1:0]      g_idx;
  logic               busy;
  logic               tmo_hit;

  assign elig = req_cyc_i & req_stb_i & en_mask_i;
  assign busy = (state_q == BUSY);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .LW      (LW)
  ) u_pick (
    .req   (elig),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) g_idx = LW'(i);
    end
  end

`ifdef QSPI_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero while idle so every grant starts a fresh count.
  assign cnt_d   = busy ? cnt_q + 1'b1 : '0;
  assign tmo_hit = busy && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tmo_hit || dn_ack_i) begin
          last_d  = g_idx;
          grant_d = '0;
          state_d = IDLE;
        end else if (!req_cyc_i[g_idx]) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // The watchdog cycle drops cyc so the controller cannot ack into an errored slot.
  always_comb begin
    dn_cyc_o  = 1'b0;
    dn_stb_o  = 1'b0;
    dn_we_o   = 1'b0;
    dn_sel_o  = '0;
    dn_adr_o  = '0;
    dn_dat_o  = '0;
    req_dat_o = '0;
    req_ack_o = '0;
    req_err_o = '0;
    if (busy) begin
      dn_cyc_o  = req_cyc_i[g_idx] & ~tmo_hit;
      dn_stb_o  = req_stb_i[g_idx] & ~tmo_hit;
      dn_we_o   = req_we_i[g_idx];
      dn_sel_o  = req_sel_i[int'(g_idx)*WB_SELW +: WB_SELW];
      dn_adr_o  = req_adr_i[int'(g_idx)*ADDR_W +: ADDR_W];
      dn_dat_o  = req_dat_i[int'(g_idx)*WB_DW +: WB_DW];
      req_dat_o = dn_dat_i;
      req_ack_o = grant_q & {NUM_REQ{dn_ack_i & ~tmo_hit & ~rst_i}};
      req_err_o = grant_q & {NUM_REQ{tmo_hit & ~rst_i}};
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy;

endmodule

// File: tb/tb_qspi_mem_arb.sv
// Scoreboard bench for qspi_mem_arb; the watchdog scenario follows
// QSPI_MEM_ARB_TIMEOUT_EN the same way the design does.
module tb_qspi_mem_arb;

  localparam int N  = 8;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    en_mask;
  logic [N-1:0]    cyc_r, stb_r, we_r;
  logic [3:0]      sel_a  [N];
  logic [AW-1:0]   adr_a  [N];
  logic [31:0]     wdat_a [N];
  logic [N*4-1:0]  req_sel;
  logic [N*AW-1:0] req_adr;
  logic [N*32-1:0] req_dat;
  logic [31:0]     req_dat_o;
  logic [N-1:0]    req_ack_o, req_err_o, grant_o;
  logic            dn_cyc_o, dn_stb_o, dn_we_o, busy_o;
  logic [3:0]      dn_sel_o;
  logic [AW-1:0]   dn_adr_o;
  logic [31:0]     dn_dat_o, dn_dat_i;
  logic            dn_ack_i;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_sel[i*4 +: 4]   = sel_a[i];
      req_adr[i*AW +: AW] = adr_a[i];
      req_dat[i*32 +: 32] = wdat_a[i];
    end
  end

  qspi_mem_arb #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_mask_i (en_mask),
    .req_cyc_i (cyc_r),
    .req_stb_i (stb_r),
    .req_we_i  (we_r),
    .req_sel_i (req_sel),
    .req_adr_i (req_adr),
    .req_dat_i (req_dat),
    .req_dat_o (req_dat_o),
    .req_ack_o (req_ack_o),
    .req_err_o (req_err_o),
    .dn_cyc_o  (dn_cyc_o),
    .dn_stb_o  (dn_stb_o),
    .dn_we_o   (dn_we_o),
    .dn_sel_o  (dn_sel_o),
    .dn_adr_o  (dn_adr_o),
    .dn_dat_o  (dn_dat_o),
    .dn_dat_i  (dn_dat_i),
    .dn_ack_i  (dn_ack_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0]  gnt;
    logic [AW-1:0] adr;
    logic [31:0]   wdat;
    logic [31:0]   rdat;
  } exp_t;

  exp_t         sbq[$];
  logic [31:0]  rd_data = 32'h0;
  int           ack_delay = 0;
  bit           ack_en = 1'b1;
  logic [N-1:0] grant_hist = '0;

  task automatic push_exp(input int idx);
    exp_t e;
    e.gnt  = N'(1) << idx;
    e.adr  = adr_a[idx];
    e.wdat = wdat_a[idx];
    e.rdat = rd_data;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input bit on);
    cyc_r[idx] = on;
    stb_r[idx] = on;
  endtask

  task automatic do_reset();
    cyc_r = '0;
    stb_r = '0;
    rst   = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Returns on the negedge of the n-th ack; checks the one-cycle gap between transactions.
  task automatic wait_acks(input int n, input int max_cyc);
    int done = 0;
    int cyc  = 0;
    bit prev_ack  = 1'b0;
    bit prev2_ack = 1'b0;
    while (done < n && cyc < max_cyc) begin
      @(negedge clk);
      if (prev_ack)  chk("gap_idle", dn_cyc_o, 1'b0);
      if (prev2_ack) chk("gap_regrant", dn_cyc_o, 1'b1);
      prev2_ack = prev_ack;
      prev_ack  = (req_ack_o != '0);
      if (prev_ack) done++;
      cyc++;
    end
    if (done < n) chk("ack_wait_expired", done, n);
  endtask

  // Downstream QSPI controller model: acks ack_delay cycles after cyc/stb appear.
  initial begin
    int wcnt = 0;
    dn_ack_i = 1'b0;
    dn_dat_i = '0;
    forever begin
      @(posedge clk);
      #2;
      dn_ack_i = 1'b0;
      if (ack_en && dn_cyc_o && dn_stb_o) begin
        if (wcnt == ack_delay) begin
          dn_ack_i = 1'b1;
          dn_dat_i = rd_data;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      grant_hist = grant_hist | grant_o;
      if (req_ack_o != '0) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_ack", req_ack_o, '0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_grant", grant_o, e.gnt);
          chk("sb_ack", req_ack_o, e.gnt);
          chk("sb_cyc", dn_cyc_o, 1'b1);
          chk("sb_adr", dn_adr_o, e.adr);
          chk("sb_wdat", dn_dat_o, e.wdat);
          chk("sb_rdat", req_dat_o, e.rdat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    bit err_seen;
    rst     = 1'b1;
    en_mask = '1;
    cyc_r   = '0;
    stb_r   = '0;
    we_r    = '0;
    for (int i = 0; i < N; i++) begin
      sel_a[i]  = 4'hF;
      adr_a[i]  = 24'h001000 + AW'(i);
      wdat_a[i] = 32'hA000_0000 + 32'(i);
    end
    step();
    step();
    @(negedge clk);
    chk("rst_grant", grant_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_dn_cyc", dn_cyc_o, 1'b0);
    chk("rst_dn_adr", dn_adr_o, '0);
    chk("rst_ack", req_ack_o, '0);
    chk("rst_err", req_err_o, '0);
    chk("rst_rdat", req_dat_o, '0);
    rst = 1'b0;

    // Single request from core 3
    adr_a[3]  = 24'h000100;
    rd_data   = 32'hDEADBEEF;
    ack_delay = 5;
    push_exp(3);
    step();
    set_req(3, 1'b1);
    @(negedge clk);
    chk("single_arb_cycle", dn_cyc_o, 1'b0);
    step();
    @(negedge clk);
    chk("single_grant", grant_o, 8'h08);
    chk("single_dn_cyc", dn_cyc_o, 1'b1);
    chk("single_dn_adr", dn_adr_o, 24'h000100);
    chk("single_dn_sel", dn_sel_o, 4'hF);
    k = 0;
    while (req_ack_o == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("single_ack_lat", k, 5);
    chk("single_ack", req_ack_o, 8'h08);
    chk("single_rdat", req_dat_o, 32'hDEADBEEF);
    step();
    set_req(3, 1'b0);
    @(negedge clk);
    chk("single_idle_after", busy_o, 1'b0);
    adr_a[3] = 24'h001003;

    // Contention 0, 1, 5
    do_reset();
    ack_delay = 0;
    rd_data   = 32'h1234_5678;
    for (int r = 0; r < 2; r++) begin
      push_exp(0);
      push_exp(1);
      push_exp(5);
    end
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    set_req(5, 1'b1);
    wait_acks(6, 80);
    step();
    cyc_r = '0;
    stb_r = '0;
    step();

    // Mask and wrap: requester 6 first so last=6
    do_reset();
    ack_delay = 1;
    rd_data   = 32'h0BAD_F00D;
    push_exp(6);
    set_req(6, 1'b1);
    wait_acks(1, 30);
    step();
    set_req(6, 1'b0);
    step();
    en_mask    = 8'h81;
    grant_hist = '0;
    rd_data    = 32'h5A5A_0001;
    push_exp(7);
    push_exp(0);
    push_exp(7);
    set_req(0, 1'b1);
    set_req(7, 1'b1);
    set_req(4, 1'b1);
    wait_acks(3, 60);
    step();
    cyc_r = '0;
    stb_r = '0;
    step();
    chk("masked_never_granted", grant_hist[4], 1'b0);
    en_mask = '1;

    // Abort: requester 2 drops cyc; last stays 7
    ack_en = 1'b0;
    set_req(2, 1'b1);
    @(negedge clk);
    chk("abort_arb_cycle", grant_o, '0);
    step();
    @(negedge clk);
    chk("abort_grant", grant_o, 8'h04);
    step();
    set_req(2, 1'b0);
    @(negedge clk);
    chk("abort_dn_cyc", dn_cyc_o, 1'b0);
    chk("abort_no_ack", req_ack_o, '0);
    step();
    @(negedge clk);
    chk("abort_idle", busy_o, 1'b0);
    chk("abort_grant_clr", grant_o, '0);
    ack_en  = 1'b1;
    rd_data = 32'hC0FF_EE00;
    push_exp(1);
    push_exp(3);
    set_req(1, 1'b1);
    set_req(3, 1'b1);
    wait_acks(2, 40);
    step();
    cyc_r = '0;
    stb_r = '0;
    step();

    // Reset while busy
    ack_en = 1'b0;
    set_req(5, 1'b1);
    step();
    @(negedge clk);
    chk("rstmid_grant", grant_o, 8'h20);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_ack", req_ack_o, '0);
    step();
    rst = 1'b0;
    set_req(0, 1'b1);
    @(negedge clk);
    chk("rstmid_grant_clr", grant_o, '0);
    chk("rstmid_dn_cyc", dn_cyc_o, 1'b0);
    step();
    @(negedge clk);
    chk("rstmid_first_grant", grant_o, 8'h01);
    step();
    cyc_r = '0;
    stb_r = '0;
    step();
    step();

`ifdef QSPI_MEM_ARB_TIMEOUT_EN
    do_reset();
    ack_en = 1'b0;
    set_req(2, 1'b1);
    set_req(6, 1'b1);
    k = 0;
    while (grant_o == '0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_grant", grant_o, 8'h04);
    k = 0;
    while (req_err_o == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", k, 15);
    chk("tmo_err", req_err_o, 8'h04);
    chk("tmo_dn_cyc", dn_cyc_o, 1'b0);
    @(negedge clk);
    chk("tmo_err_pulse", req_err_o, '0);
    chk("tmo_idle", busy_o, 1'b0);
    @(negedge clk);
    chk("tmo_next_grant", grant_o, 8'h40);
    step();
    cyc_r = '0;
    stb_r = '0;
    step();
    step();
`else
    do_reset();
    ack_en   = 1'b0;
    err_seen = 1'b0;
    set_req(2, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_err_o != '0) err_seen = 1'b1;
    end
    chk("noto_err", err_seen, 1'b0);
    chk("noto_still_busy", busy_o, 1'b1);
    step();
    set_req(2, 1'b0);
    step();
    step();
`endif

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
